// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with valid bit, stall/flush control and
// saturating bubble/stall event counters for performance debug.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 5,
    parameter int MEM_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               ValidIn,
    input  logic [REG_AW-1:0]  RSIn,
    input  logic [REG_AW-1:0]  RTIn,
    input  logic [REG_AW-1:0]  DestRegIn,
    input  logic               RegWriteIn,
    input  logic               ALUSrcIn,
    input  logic               MemToRegIn,
    input  logic [MEM_W-1:0]   MemWriteIn,
    input  logic [MEM_W-1:0]   MemReadIn,
    input  logic [ALUOP_W-1:0] ALUControlIn,
    input  logic [DATA_W-1:0]  PCAddResultIn,
    input  logic [DATA_W-1:0]  ReadData1In,
    input  logic [DATA_W-1:0]  ReadData2In,
    input  logic [DATA_W-1:0]  SignExtIn,
    output logic               ValidOut,
    output logic [REG_AW-1:0]  RSOut,
    output logic [REG_AW-1:0]  RTOut,
    output logic [REG_AW-1:0]  DestRegOut,
    output logic               RegWriteOut,
    output logic               ALUSrcOut,
    output logic               MemToRegOut,
    output logic [MEM_W-1:0]   MemWriteOut,
    output logic [MEM_W-1:0]   MemReadOut,
    output logic [ALUOP_W-1:0] ALUControlOut,
    output logic [DATA_W-1:0]  PCAddResultOut,
    output logic [DATA_W-1:0]  ReadData1Out,
    output logic [DATA_W-1:0]  ReadData2Out,
    output logic [DATA_W-1:0]  SignExtOut,
    output logic [CNT_W-1:0]   BubbleCount,
    output logic [CNT_W-1:0]   StallCount
);

    // Stage control: Flush inserts a bubble (and beats Stall); Stall holds the
    // slot; otherwise the slot loads, and an invalid decode slot loads as a bubble.
    logic do_bubble;
    logic do_hold;

    always_comb begin
        do_bubble = Flush | (~Stall & ~ValidIn);
        do_hold   = ~Flush & Stall;
    end

    always_ff @(posedge Clk) begin
        if (Reset || do_bubble) begin
            ValidOut       <= 1'b0;
            RSOut          <= '0;
            RTOut          <= '0;
            DestRegOut     <= '0;
            RegWriteOut    <= 1'b0;
            ALUSrcOut      <= 1'b0;
            MemToRegOut    <= 1'b0;
            MemWriteOut    <= '0;
            MemReadOut     <= '0;
            ALUControlOut  <= '0;
            PCAddResultOut <= '0;
            ReadData1Out   <= '0;
            ReadData2Out   <= '0;
            SignExtOut     <= '0;
        end else if (!do_hold) begin
            ValidOut       <= 1'b1;
            RSOut          <= RSIn;
            RTOut          <= RTIn;
            DestRegOut     <= DestRegIn;
            RegWriteOut    <= RegWriteIn;
            ALUSrcOut      <= ALUSrcIn;
            MemToRegOut    <= MemToRegIn;
            MemWriteOut    <= MemWriteIn;
            MemReadOut     <= MemReadIn;
            ALUControlOut  <= ALUControlIn;
            PCAddResultOut <= PCAddResultIn;
            ReadData1Out   <= ReadData1In;
            ReadData2Out   <= ReadData2In;
            SignExtOut     <= SignExtIn;
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            BubbleCount <= '0;
            StallCount  <= '0;
        end else begin
            if (do_bubble && (BubbleCount != {CNT_W{1'b1}}))
                BubbleCount <= BubbleCount + 1'b1;
            if (do_hold && (StallCount != {CNT_W{1'b1}}))
                StallCount <= StallCount + 1'b1;
        end
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised decode-to-execute pipeline register; next generation of the fixed-width ID/EX latch.
- Adds a valid bit, stall (hold), flush (bubble insertion) and forced zeroing of side-effecting controls on bubbles.
- Adds saturating bubble/stall event counters for performance debug.
- Sits between the decode stage and the execute stage. Driven by the hazard unit (Stall) and branch/jump resolution (Flush).

Parameters:
- DATA_W, 32, width of PC+4, register read data and sign-extended immediate.
- REG_AW, 5, register-file address width (RS, RT, destination).
- ALUOP_W, 5, ALU control width.
- MEM_W, 2, width of memory-write and memory-read size/enable codes.
- CNT_W, 16, width of each event counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold all stage contents this cycle.
- Flush  in  1  replace stage contents with a bubble this cycle.
- ValidIn  in  1  decode slot holds a real instruction.
- RSIn, RTIn, DestRegIn  in  REG_AW each  source and destination register numbers.
- RegWriteIn, ALUSrcIn, MemToRegIn  in  1 each  control bits.
- MemWriteIn, MemReadIn  in  MEM_W each  memory control codes.
- ALUControlIn  in  ALUOP_W  ALU operation.
- PCAddResultIn, ReadData1In, ReadData2In, SignExtIn  in  DATA_W each  datapath operands.
- ValidOut  out  1  execute slot holds a real instruction.
- RSOut, RTOut, DestRegOut  out  REG_AW each  registered register numbers.
- RegWriteOut, ALUSrcOut, MemToRegOut  out  1 each  registered control bits.
- MemWriteOut, MemReadOut  out  MEM_W each  registered memory controls.
- ALUControlOut  out  ALUOP_W  registered ALU operation.
- PCAddResultOut, ReadData1Out, ReadData2Out, SignExtOut  out  DATA_W each  registered operands.
- BubbleCount  out  CNT_W  bubbles inserted since reset.
- StallCount  out  CNT_W  stall cycles since reset.

Behaviour:
- Clock/reset: single clock Clk; Reset is synchronous, active-high, sampled on the rising edge of Clk.
- Reset: every output, including ValidOut and both counters, is 0 on the edge after Reset=1. Reset overrides all other inputs.
- Update priority per edge: Reset > Flush > Stall > Load. Exactly one action per cycle.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N. No combinational input-to-output paths.
- Flush (Flush=1, Reset=0):
  - ValidOut <= 0.
  - All control outputs (RegWrite, ALUSrc, MemToReg, MemWrite, MemRead, ALUControl) <= 0.
  - All register-number and datapath outputs <= 0.
  - BubbleCount increments.
- Flush takes precedence over a simultaneous Stall. That cycle counts as a bubble, not a stall.
- Stall (Stall=1, Flush=0): all outputs hold their previous value, including ValidOut. StallCount increments.
- Load (Stall=0, Flush=0):
  - ValidIn=1: every output captures its corresponding input; ValidOut <= 1.
  - ValidIn=0: treated as a bubble. Result is identical to Flush (all outputs 0, ValidOut 0) and BubbleCount increments.
- Invariant: ValidOut=0 implies RegWriteOut=0, MemWriteOut=0 and MemReadOut=0 in every cycle. A bubble never writes the register file or memory.
- Counters: unsigned, increment by 1, saturate at 2^CNT_W-1 (no wrap). Cleared only by Reset.
- Widths: all fields are pass-through at declared widths; no truncation or extension inside the block.
- Reset asserted mid-stall or mid-flush: reset wins that cycle. The next non-reset cycle follows normal priority.

Test Plan:
- Reset: drive random inputs with Reset=1 for 2 cycles -> all outputs 0, ValidOut=0, BubbleCount=0, StallCount=0.
- Load: ValidIn=1, RegWriteIn=1, MemWriteIn=2'b01, ReadData1In=32'hDEADBEEF, DestRegIn=5'd9 -> after one edge ValidOut=1, RegWriteOut=1, MemWriteOut=2'b01, ReadData1Out=32'hDEADBEEF, DestRegOut=9.
- Stall hold: after the load above, Stall=1 for 3 cycles while inputs change to 32'h12345678 -> outputs stay 32'hDEADBEEF and ValidOut=1; StallCount=3.
- Flush over stall: Stall=1 and Flush=1 together -> ValidOut=0, RegWriteOut=0, MemWriteOut=0, ReadData1Out=0; BubbleCount +1, StallCount unchanged.
- Invalid load: ValidIn=0 with RegWriteIn=1, MemReadIn=2'b11 -> ValidOut=0, RegWriteOut=0, MemReadOut=0; BubbleCount +1.
- Saturation: CNT_W=3, Stall=1 for 10 cycles -> StallCount reads 7 and holds at 7.
